// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: default widths,
// the fetch stride and the queue occupancy counter width.
package if_prefetch_queue_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_DEPTH  = 4;

    // Byte distance between consecutive fetch addresses.
    localparam int PC_STEP    = 4;

    // The count must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_queue_fifo.sv
// Synchronous circular FIFO holding {pc, inst} entries for the prefetch
// queue. Flush empties it in one edge. The head entry is read straight
// from storage and forced to zero while the FIFO is empty, so stale
// contents never reach the decode side.
module inst_queue_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow locally, and let flush win outright.
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        rdata   = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; no reset needed because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch prefetch queue. Issues sequential fetches to a ROM with
// one-cycle read latency, pairs each returning word with the address that
// requested it, and buffers up to DEPTH entries for decode. A fetch is only
// issued when the queue plus the single outstanding request still fit, so
// the returning word always has a slot. Redirect flushes everything, drops
// the word arriving that cycle, and restarts fetching at redirect_pc.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [ADDR_W-1:0]        fetch_pc;
    logic                     inflight_q;
    logic [ADDR_W-1:0]        inflight_pc_q;
    logic [CNT_W-1:0]         count;
    logic                     fifo_empty;
    logic [ADDR_W+INST_W-1:0] head;
    logic [OCC_W-1:0]         occupancy;
    logic                     issue;
    logic                     enq;
    logic                     deq;

    // Issue/enqueue/dequeue decisions; redirect dominates all of them.
    always_comb begin
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        issue     = !rst && !redirect && (occupancy < DEPTH_OCC);
        enq       = inflight_q && !redirect;
        deq       = !fifo_empty && !stall && !redirect;
    end

    assign rom_ce   = issue;
    assign rom_addr = fetch_pc;

    // Fetch address and the record of the single outstanding ROM request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            fetch_pc      <= redirect_pc;
            inflight_q    <= 1'b0;
        end else if (issue) begin
            inflight_q    <= 1'b1;
            inflight_pc_q <= fetch_pc;
            fetch_pc      <= fetch_pc + ADDR_W'(PC_STEP);
        end else begin
            inflight_q    <= 1'b0;
        end
    end

    inst_queue_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (enq),
        .wdata ({inflight_pc_q, rom_inst}),
        .pop   (deq),
        .rdata (head),
        .count (count),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head[ADDR_W+INST_W-1:INST_W];
    assign out_inst  = head[INST_W-1:0];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a per-cycle vector table covering
// reset release, stall/backpressure, redirects and mid-stream reset, plus a
// second instance with RESET_PC near the top of the address space.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        stall1    = 1'b0;
    logic        redirect1 = 1'b0;
    logic [31:0] redirect_pc1 = 32'h0;
    logic        rom_ce1;
    logic [31:0] rom_addr1;
    logic [31:0] rom_inst1;
    logic        out_valid1;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;

    int checks   = 0;
    int failures = 0;
    int cur_row  = -1;

    always #5 clk = ~clk;

    if_prefetch_queue dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst)
    );

    if_prefetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk(clk), .rst(rst), .rom_ce(rom_ce1), .rom_addr(rom_addr1), .rom_inst(rom_inst1),
        .stall(stall1), .redirect(redirect1), .redirect_pc(redirect_pc1),
        .out_valid(out_valid1), .out_pc(out_pc1), .out_inst(out_inst1)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // ROM models: one-cycle read latency, garbage when not requested.
    always @(posedge clk) begin
        rom_inst  <= rom_ce  ? rom_word(rom_addr)  : 32'hDEAD_BEEF;
        rom_inst1 <= rom_ce1 ? rom_word(rom_addr1) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        chk_out;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                                input logic ce, input logic [31:0] a,
                                input logic c, input logic v, input logic [31:0] pc);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = d; t.redirect_pc = rpc;
        t.exp_ce = ce; t.exp_addr = a; t.chk_out = c; t.exp_valid = v; t.exp_pc = pc;
        return t;
    endfunction

    logic [31:0] wrap_seq [4];

    initial begin
        //                   rst  stl  rdr  rdr_pc      ce   addr        chk  ov   out_pc
        // reset release, one instruction per cycle
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h000,   1'b1,1'b0,32'h0));   // c0
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h004,   1'b1,1'b0,32'h0));   // c1
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h008,   1'b1,1'b1,32'h000)); // c2
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h00C,   1'b1,1'b1,32'h004));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h010,   1'b1,1'b1,32'h008));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h014,   1'b1,1'b1,32'h00C));
        // stall for 10 cycles: queue fills, fetch stops, head holds
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h018,   1'b1,1'b1,32'h010)); // c6
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h01C,   1'b1,1'b1,32'h010));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,32'h020,   1'b1,1'b1,32'h010)); // c8..c15
        // release: drains in order, refetch resumes
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b0,32'h020,   1'b1,1'b1,32'h010)); // c16
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h020,   1'b1,1'b1,32'h014));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h024,   1'b1,1'b1,32'h018));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h028,   1'b1,1'b1,32'h01C));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h02C,   1'b1,1'b1,32'h020));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h030,   1'b1,1'b1,32'h024));
        // one stall cycle brings the queue to 3 with one in flight, then redirect
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h034,   1'b1,1'b1,32'h028)); // c22
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h100,   1'b0,32'h038,   1'b1,1'b1,32'h028)); // c23
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h100,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h104,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h108,   1'b1,1'b1,32'h100)); // c26
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h10C,   1'b1,1'b1,32'h104));
        // fill the queue, then redirect with stall low
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h110,   1'b1,1'b1,32'h108)); // c28
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h114,   1'b1,1'b1,32'h108));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b0,32'h118,   1'b1,1'b1,32'h108));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h200,   1'b0,32'h118,   1'b1,1'b1,32'h108)); // c31
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h200,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h204,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h208,   1'b1,1'b1,32'h200)); // c34
        // back-to-back redirects: only the second target survives
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h300,   1'b0,32'h20C,   1'b1,1'b1,32'h204)); // c35
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h400,   1'b0,32'h300,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h400,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h404,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h408,   1'b1,1'b1,32'h400)); // c39
        // fill, then reset mid-stream
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h40C,   1'b1,1'b1,32'h404)); // c40
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b1,32'h410,   1'b1,1'b1,32'h404));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b0,32'h414,   1'b1,1'b1,32'h404));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,     1'b0,32'h414,   1'b1,1'b1,32'h404));
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,     1'b0,32'h414,   1'b0,1'b0,32'h0));   // c44
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h000,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h004,   1'b1,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h008,   1'b1,1'b1,32'h000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,     1'b1,32'h00C,   1'b1,1'b1,32'h004));

        wrap_seq[0] = 32'hFFFF_FFF8;
        wrap_seq[1] = 32'hFFFF_FFFC;
        wrap_seq[2] = 32'h0000_0000;
        wrap_seq[3] = 32'h0000_0004;

        // Hand sequence: hold reset, check idle outputs while in reset.
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_ce",    32'(rom_ce),    32'h0);
        chk("rst_rom_addr",  rom_addr,       32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc",    out_pc,         32'h0);
        chk("rst_out_inst",  out_inst,       32'h0);
        chk("rst_wrap_addr", rom_addr1,      32'hFFFF_FFF8);
        chk("rst_wrap_ce",   32'(rom_ce1),   32'h0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            cur_row     = i;
            rst         = vecs[i].rst;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].redirect_pc;
            @(negedge clk);
            chk("rom_ce",   32'(rom_ce), 32'(vecs[i].exp_ce));
            chk("rom_addr", rom_addr,    vecs[i].exp_addr);
            if (vecs[i].chk_out) begin
                chk("out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
                chk("out_pc",    out_pc,         vecs[i].exp_pc);
                chk("out_inst",  out_inst,       vecs[i].exp_valid ? rom_word(vecs[i].exp_pc) : 32'h0);
            end
            // Wrapping instance runs free from the same reset release.
            if (i < 4) begin
                chk("wrap_rom_ce",   32'(rom_ce1), 32'h1);
                chk("wrap_rom_addr", rom_addr1,    wrap_seq[i]);
            end
            if (i >= 2 && i < 6) begin
                chk("wrap_out_valid", 32'(out_valid1), 32'h1);
                chk("wrap_out_pc",    out_pc1,         wrap_seq[i-2]);
                chk("wrap_out_inst",  out_inst1,       rom_word(wrap_seq[i-2]));
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
